// File: rtl/complement_decoder.sv
// complement_decoder
//   Bit-serial decoder that converts a signed word in one's- or two's-complement
//   encoding into sign-magnitude form. A word is accepted in IDLE, shifted LSB
//   first through the converter for WIDTH cycles, and the result is presented in
//   DONE until the downstream side accepts it. Latency is fixed at WIDTH edges
//   from acceptance to out_valid, independent of the data.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     in_data/in_mode are valid
//   in_ready     decoder can accept a word (IDLE only)
//   in_data      encoded signed word, MSB is the sign
//   in_mode      0 = one's complement, 1 = two's complement
//   out_valid    result fields are valid, held until accepted
//   out_ready    downstream accepts the result
//   out_sign     result sign, 1 = negative
//   out_mag      unsigned magnitude
//   out_negzero  one's-complement negative zero was decoded
module complement_decoder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_negzero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] mag_r;
  logic [CW-1:0]    cnt;
  logic             mode_r;
  logic             sign_r;
  logic             seen_one;
  logic             out_bit;
  logic             last_shift;
  logic [WIDTH-1:0] next_mag;
  logic             res_sign;
  logic [WIDTH-1:0] res_mag;
  logic             res_negzero;

  // Per-bit conversion. Two's complement uses copy-through-first-1, invert the
  // rest; seen_one remembers whether a 1 has already passed.
  always_comb begin
    out_bit = shreg[0];
    if (sign_r) begin
      if (mode_r) begin
        out_bit = shreg[0] ^ seen_one;
      end else begin
        out_bit = ~shreg[0];
      end
    end
  end

  // Converted bits enter from the MSB end so the word is in order after WIDTH shifts.
  assign next_mag   = {out_bit, mag_r[WIDTH-1:1]};
  assign last_shift = (state_q == SHIFT) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath. The result registers are loaded only on the final shift so that
  // the visible outputs keep the previous result while a new word is shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg       <= '0;
      mag_r       <= '0;
      cnt         <= '0;
      mode_r      <= 1'b0;
      sign_r      <= 1'b0;
      seen_one    <= 1'b0;
      res_sign    <= 1'b0;
      res_mag     <= '0;
      res_negzero <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            shreg    <= in_data;
            mode_r   <= in_mode;
            sign_r   <= in_data[WIDTH-1];
            seen_one <= 1'b0;
            cnt      <= '0;
          end
        end
        SHIFT: begin
          shreg <= shreg >> 1;
          mag_r <= next_mag;
          cnt   <= cnt + CW'(1);
          if (sign_r && mode_r) seen_one <= seen_one | shreg[0];
          if (last_shift) begin
            res_mag     <= next_mag;
            // A two's-complement zero never reports a negative sign.
            res_sign    <= sign_r & ~(mode_r & (next_mag == '0));
            res_negzero <= sign_r & ~mode_r & (next_mag == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sign    = res_sign;
  assign out_mag     = res_mag;
  assign out_negzero = res_negzero;

endmodule

// File: doc/complement_decoder.md
# complement_decoder

Sequential decoder that recovers sign-magnitude form from a signed word in one's- or two's-complement encoding. It is the reverse-direction companion of the ALU complementer. It sits on the ALU result path ahead of display and compare logic. Conversion is bit-serial, LSB first, behind valid/ready handshakes on both sides, with a fixed latency that does not depend on the data.

## Interface
Parameters:
- WIDTH, 4, word width in bits; legal range 2 to 16.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  in_data and in_mode are valid.
- in_ready  output  1  decoder can accept a word; high only in IDLE.
- in_data  input  WIDTH  encoded signed word; MSB is the sign.
- in_mode  input  1  encoding select: 0 = one's complement, 1 = two's complement.
- out_valid  output  1  result fields are valid; held until accepted.
- out_ready  input  1  downstream accepts the result.
- out_sign  output  1  sign of the result; 1 = negative.
- out_mag  output  WIDTH  unsigned magnitude.
- out_negzero  output  1  one's-complement negative zero (all ones) was decoded.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE
  - in_ready = 1.
  - When in_valid = 1 at a rising edge, the following are registered:
    - in_data into the shift register.
    - in_mode into the mode register.
    - in_data[WIDTH-1] into the sign register.
  - Also at that edge: seen_one is cleared, the bit counter is cleared, and the FSM moves to SHIFT.
- SHIFT: one bit per cycle, LSB first. For each bit b, the output bit o is:
  - Sign = 0: o = b.
  - Sign = 1 and mode = 0: o = ~b.
  - Sign = 1 and mode = 1: o = b ^ seen_one, then seen_one is set to seen_one | b. This is the copy-through-first-1, invert-the-rest rule.
- Each o is shifted into the magnitude register from the MSB end, so after WIDTH shifts it is correctly ordered.
- The counter increments each SHIFT cycle. When the counter reaches WIDTH-1, the FSM moves to DONE.
- DONE
  - out_valid = 1.
  - out_sign = sign register, except it is forced to 0 for two's-complement zero.
  - out_negzero = sign & ~mode & (magnitude == 0).
  - On out_valid & out_ready, the FSM returns to IDLE.
- Width rules
  - out_mag is an unsigned WIDTH-bit value, so there is no overflow.
  - The two's-complement most negative value 1000..0 decodes to sign 1, magnitude 2^(WIDTH-1).
  - In one's complement, the all-ones input decodes to sign 1, magnitude 0, out_negzero = 1.
- in_valid is ignored outside IDLE.
- out_ready is ignored outside DONE.

## Timing
- Reset: asynchronous assertion forces the following immediately:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - out_sign = 0, out_mag = 0, out_negzero = 0.
  - Internal registers are cleared.
- Reset asserted in the middle of SHIFT or DONE discards the word. No partial result is ever presented.
- After deassertion, the first acceptance is possible at the next rising edge.
- Latency: if acceptance happens at edge k, out_valid rises after edge k+WIDTH, i.e. WIDTH edges later.
- out_sign, out_mag and out_negzero are stable for as long as out_valid is high.
- out_mag and out_sign hold their last result after the handshake until the next DONE; only out_valid drops.
- Handshakes
  - A transfer occurs on an edge where valid and ready are both 1.
  - out_valid drops the cycle after the output transfer.
  - in_ready rises in that same cycle.
  - Back-to-back throughput is one word per WIDTH+2 cycles.
- Simultaneous events: in DONE with out_ready = 1 and in_valid = 1, the input is not taken, because in_ready = 0. It is accepted on the following edge in IDLE.
- Backpressure: with out_ready held low, DONE and all outputs are held indefinitely.

## Test plan
All scenarios use WIDTH = 4.
- Reset: rst_n pulsed low between edges -> outputs immediately reset to in_ready = 1, out_valid = 0, out_mag = 0000, out_sign = 0, out_negzero = 0.
- Two's-complement decode: mode 1, each input accepted at edge k, out_valid rising after edge k+4 ->
  - 1010 -> sign 1, mag 0110.
  - 1000 -> sign 1, mag 1000.
  - 0000 -> sign 0, mag 0000.
  - 0110 -> sign 0, mag 0110.
- One's-complement decode: mode 0 ->
  - 1010 -> sign 1, mag 0101, negzero 0.
  - 1111 -> sign 1, mag 0000, negzero 1.
  - 0111 -> sign 0, mag 0111.
- Round trip: all 16 values of A are passed through complement (select 0 and select 1) and then decoded with the matching mode. Required:
  - Outputs reproduce A's sign-magnitude pair.
  - Exception: the negative-zero cases, where A = 0 with select 0 decodes with negzero = 1.
- Backpressure: out_ready held low for 10 cycles while in DONE, with in_valid held high and changing data -> result held constant, in_ready = 0, no new word accepted. Then out_ready pulses once -> exactly one transfer, in_ready = 1 in the next cycle.
- Mid-operation reset: rst_n asserted two cycles after acceptance of 1010/mode 1 -> no out_valid. A following word 0011/mode 1 -> sign 0, mag 0011 with full 4-edge latency.
